// File: rtl/axi_addr_gen_2d.sv
// Purpose : splits a 2-D transfer (num_rows x row_bytes, rows stride_bytes apart) into AXI INCR
//           burst requests of at most MAX_BURST beats for the AR/AW channel master.
// Latency : first request valid 1 cycle after start; one burst per cycle while ready; done 1 cycle after last fire.
// Backpr. : req_* are registered and held stable while req_valid & !req_ready.
//
// Ports:
//   clk, rstn                          clock, async active-low reset
//   start, base_addr, row_bytes,       command strobe and shape (sampled only when idle);
//   num_rows, stride_bytes             stride_bytes==0 means rows are contiguous
//   req_valid/req_ready                burst request handshake
//   req_addr, req_len                  burst start byte address, AXI LEN (beats-1)
//   req_row_last, req_last             burst ends a row / ends the whole command
//   busy, done, err                    not idle; completion pulse; reject pulse (with done)
//
// Build option: define AXI_AGEN_4K_SPLIT_EN to also split bursts at 4 KB page boundaries.
module axi_addr_gen_2d #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int ROW_W     = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [31:0]       row_bytes,
  input  logic [ROW_W-1:0]  num_rows,
  input  logic [31:0]       stride_bytes,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  output logic [7:0]        req_len,
  output logic              req_row_last,
  output logic              req_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int          BEAT_BYTES = DATA_W / 8;
  localparam int          SHIFT      = $clog2(BEAT_BYTES);
  localparam logic [31:0] MAX_B      = 32'(MAX_BURST);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE} state_e;

  state_e              state_q, state_d;
  // Cursor: position of the next burst to be presented after the current one.
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0]   row_base_q, row_base_d;
  logic [31:0]         rem_q, rem_d;            // beats left in the cursor's row
  logic [ROW_W-1:0]    rows_q, rows_d;          // rows left, including the cursor's row
  logic [31:0]         pitch_q, pitch_d;
  logic [31:0]         row_beats_q, row_beats_d;
  logic                req_valid_q, req_valid_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [7:0]          req_len_q, req_len_d;
  logic                req_row_last_q, req_row_last_d;
  logic                req_last_q, req_last_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  // When idle the burst calculator looks straight at the command inputs, so the
  // first burst is registered on the start edge; otherwise it looks at the cursor.
  logic                idle;
  logic [ADDR_W-1:0]   src_addr, src_base, next_addr, next_base;
  logic [31:0]         src_rem, src_pitch, src_row_beats, beats;
  logic [ROW_W-1:0]    src_rows;
  logic                row_last, last, misalign, empty, fire, load;
`ifdef AXI_AGEN_4K_SPLIT_EN
  logic [31:0]         page_beats;
`endif

  always_comb begin
    idle          = (state_q == S_IDLE);
    src_addr      = idle ? base_addr : cur_addr_q;
    src_base      = idle ? base_addr : row_base_q;
    src_rem       = idle ? (row_bytes >> SHIFT) : rem_q;
    src_rows      = idle ? num_rows : rows_q;
    src_pitch     = idle ? ((stride_bytes != 32'd0) ? stride_bytes : row_bytes) : pitch_q;
    src_row_beats = idle ? (row_bytes >> SHIFT) : row_beats_q;

    beats = (src_rem < MAX_B) ? src_rem : MAX_B;
`ifdef AXI_AGEN_4K_SPLIT_EN
    // Aligned addresses always leave at least one beat before the page end.
    page_beats = 32'((13'h1000 - {1'b0, src_addr[11:0]}) >> SHIFT);
    if (page_beats < beats) beats = page_beats;
`endif
    row_last  = (beats == src_rem);
    last      = row_last && (src_rows == ROW_W'(1));
    next_addr = src_addr + ADDR_W'(beats << SHIFT);
    next_base = src_base + ADDR_W'(src_pitch);

    misalign = (|base_addr[SHIFT-1:0]) || (|row_bytes[SHIFT-1:0]);
    empty    = (row_bytes == 32'd0) || (num_rows == '0);
    fire     = req_valid_q && req_ready;
  end

  always_comb begin
    state_d        = state_q;
    cur_addr_d     = cur_addr_q;
    row_base_d     = row_base_q;
    rem_d          = rem_q;
    rows_d         = rows_q;
    pitch_d        = pitch_q;
    row_beats_d    = row_beats_q;
    req_valid_d    = req_valid_q;
    req_addr_d     = req_addr_q;
    req_len_d      = req_len_q;
    req_row_last_d = req_row_last_q;
    req_last_d     = req_last_q;
    done_d         = 1'b0;
    err_d          = 1'b0;
    load           = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (misalign || empty) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = misalign;
          end else begin
            state_d     = S_EMIT;
            pitch_d     = src_pitch;
            row_beats_d = src_row_beats;
            load        = 1'b1;
          end
        end
      end
      S_EMIT: begin
        if (fire) begin
          if (req_last_q) begin
            state_d        = S_DONE;
            done_d         = 1'b1;
            req_valid_d    = 1'b0;
            req_addr_d     = '0;
            req_len_d      = '0;
            req_row_last_d = 1'b0;
            req_last_d     = 1'b0;
          end else begin
            load = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      req_valid_d    = 1'b1;
      req_addr_d     = src_addr;
      req_len_d      = 8'(beats - 32'd1);
      req_row_last_d = row_last;
      req_last_d     = last;
      if (row_last) begin
        row_base_d = next_base;
        cur_addr_d = next_base;
        rem_d      = src_row_beats;
        rows_d     = src_rows - ROW_W'(1);
      end else begin
        row_base_d = src_base;
        cur_addr_d = next_addr;
        rem_d      = src_rem - beats;
        rows_d     = src_rows;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= S_IDLE;
      cur_addr_q     <= '0;
      row_base_q     <= '0;
      rem_q          <= '0;
      rows_q         <= '0;
      pitch_q        <= '0;
      row_beats_q    <= '0;
      req_valid_q    <= 1'b0;
      req_addr_q     <= '0;
      req_len_q      <= '0;
      req_row_last_q <= 1'b0;
      req_last_q     <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cur_addr_q     <= cur_addr_d;
      row_base_q     <= row_base_d;
      rem_q          <= rem_d;
      rows_q         <= rows_d;
      pitch_q        <= pitch_d;
      row_beats_q    <= row_beats_d;
      req_valid_q    <= req_valid_d;
      req_addr_q     <= req_addr_d;
      req_len_q      <= req_len_d;
      req_row_last_q <= req_row_last_d;
      req_last_q     <= req_last_d;
      done_q         <= done_d;
      err_q          <= err_d;
    end
  end

  assign req_valid    = req_valid_q;
  assign req_addr     = req_addr_q;
  assign req_len      = req_len_q;
  assign req_row_last = req_row_last_q;
  assign req_last     = req_last_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_axi_addr_gen_2d.sv
// Directed bench for axi_addr_gen_2d (DATA_W=32, MAX_BURST=16) with hand-computed burst lists.
module tb_axi_addr_gen_2d;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [31:0] base_addr;
  logic [31:0] row_bytes;
  logic [15:0] num_rows;
  logic [31:0] stride_bytes;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic        req_row_last;
  logic        req_last;
  logic        busy;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;

  logic [31:0] q_addr[$];
  logic [7:0]  q_len[$];
  logic        q_rl[$];
  logic        q_last[$];
  int          done_at;
  int          last_fire;
  logic        done_err;
  logic        saw_valid;

  axi_addr_gen_2d #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(16), .ROW_W(16)) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .row_bytes(row_bytes),
    .num_rows(num_rows), .stride_bytes(stride_bytes), .req_valid(req_valid),
    .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .req_row_last(req_row_last), .req_last(req_last), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Issues one command with req_ready held high and records every fired burst.
  task automatic run_cmd(input logic [31:0] base, input logic [31:0] row,
                         input logic [15:0] rows, input logic [31:0] stride);
    int cyc;
    q_addr.delete(); q_len.delete(); q_rl.delete(); q_last.delete();
    done_at = -1; last_fire = -1; done_err = 1'b0; saw_valid = 1'b0;
    @(negedge clk);
    base_addr = base; row_bytes = row; num_rows = rows; stride_bytes = stride; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 200 && done_at < 0) begin
      if (req_valid) saw_valid = 1'b1;
      if (req_valid && req_ready) begin
        q_addr.push_back(req_addr); q_len.push_back(req_len);
        q_rl.push_back(req_row_last); q_last.push_back(req_last);
        last_fire = cyc;
      end
      if (done) begin
        done_at  = cyc;
        done_err = err;
      end
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", 64'(done_at >= 0), 64'd1);
  endtask

  task automatic chk_burst(input string tag, input int i, input logic [31:0] a,
                           input logic [7:0] l, input logic rl, input logic ls);
    chk({tag, "_addr"}, q_addr[i], a);
    chk({tag, "_len"},  q_len[i], l);
    chk({tag, "_rl"},   q_rl[i], rl);
    chk({tag, "_last"}, q_last[i], ls);
  endtask

  task automatic chk_test1(input string tag);
    chk({tag, "_n"}, q_addr.size(), 4);
    chk_burst({tag, "_b0"}, 0, 32'h1000, 8'd15, 1'b0, 1'b0);
    chk_burst({tag, "_b1"}, 1, 32'h1040, 8'd15, 1'b0, 1'b0);
    chk_burst({tag, "_b2"}, 2, 32'h1080, 8'd15, 1'b0, 1'b0);
    chk_burst({tag, "_b3"}, 3, 32'h10C0, 8'd15, 1'b1, 1'b1);
    chk({tag, "_first_fire_to_done"}, done_at, 5);
    chk({tag, "_done_lat"}, done_at, last_fire + 1);
    chk({tag, "_err"}, done_err, 1'b0);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; req_ready = 1'b1;
    base_addr = '0; row_bytes = '0; num_rows = '0; stride_bytes = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", req_valid, 1'b0);
    chk("rst_addr", req_addr, 32'h0);
    chk("rst_len", req_len, 8'h0);
    chk("rst_flags", {req_row_last, req_last, busy, done, err}, 5'b0);
    rstn = 1'b1;

    // Contiguous single row
    run_cmd(32'h1000, 32'd256, 16'd1, 32'd0);
    chk_test1("t1");

    // 2-D with stride
    run_cmd(32'h2000, 32'd40, 16'd3, 32'h100);
    chk("t2s_n", q_addr.size(), 3);
    chk_burst("t2s_b0", 0, 32'h2000, 8'd9, 1'b1, 1'b0);
    chk_burst("t2s_b1", 1, 32'h2100, 8'd9, 1'b1, 1'b0);
    chk_burst("t2s_b2", 2, 32'h2200, 8'd9, 1'b1, 1'b1);
    chk("t2s_done_lat", done_at, last_fire + 1);

    // 2-D with stride 0 -> contiguous rows
    run_cmd(32'h2000, 32'd40, 16'd3, 32'd0);
    chk("t2c_n", q_addr.size(), 3);
    chk("t2c_a0", q_addr[0], 32'h2000);
    chk("t2c_a1", q_addr[1], 32'h2028);
    chk("t2c_a2", q_addr[2], 32'h2050);
    chk("t2c_last2", q_last[2], 1'b1);

    // Row longer than MAX_BURST, two rows: 18 beats -> 16 + 2 per row
    run_cmd(32'h4000, 32'd72, 16'd2, 32'h200);
    chk("t2m_n", q_addr.size(), 4);
    chk_burst("t2m_b0", 0, 32'h4000, 8'd15, 1'b0, 1'b0);
    chk_burst("t2m_b1", 1, 32'h4040, 8'd1,  1'b1, 1'b0);
    chk_burst("t2m_b2", 2, 32'h4200, 8'd15, 1'b0, 1'b0);
    chk_burst("t2m_b3", 3, 32'h4240, 8'd1,  1'b1, 1'b1);

    // Backpressure on the second burst, plus a start pulse while busy
    @(negedge clk);
    base_addr = 32'h1000; row_bytes = 32'd256; num_rows = 16'd1; stride_bytes = 32'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t3_b0_addr", req_addr, 32'h1000);
    @(negedge clk);
    req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", req_valid, 1'b1);
      chk("t3_hold_addr", req_addr, 32'h1040);
      chk("t3_hold_len", req_len, 8'd15);
      chk("t3_hold_last", req_last, 1'b0);
      chk("t3_busy", busy, 1'b1);
      start = (i == 1);
      if (i == 1) base_addr = 32'h3000;
      @(negedge clk);
    end
    start = 1'b0;
    req_ready = 1'b1;
    chk("t3_hold_after", req_addr, 32'h1040);
    @(negedge clk);
    chk("t3_b2_addr", req_addr, 32'h1080);
    @(negedge clk);
    chk("t3_b3_addr", req_addr, 32'h10C0);
    chk("t3_b3_last", req_last, 1'b1);
    @(negedge clk);
    chk("t3_done", {done, req_valid}, 2'b10);
    @(negedge clk);
    chk("t3_idle", {done, busy, req_valid}, 3'b000);
    @(negedge clk);
    chk("t3_no_ghost_cmd", req_valid, 1'b0);

    // 4 KB page crossing
    run_cmd(32'h0FF0, 32'd64, 16'd1, 32'd0);
`ifdef AXI_AGEN_4K_SPLIT_EN
    chk("t4_n", q_addr.size(), 2);
    chk_burst("t4_b0", 0, 32'h0FF0, 8'd3,  1'b0, 1'b0);
    chk_burst("t4_b1", 1, 32'h1000, 8'd11, 1'b1, 1'b1);
`else
    chk("t4_n", q_addr.size(), 1);
    chk_burst("t4_b0", 0, 32'h0FF0, 8'd15, 1'b1, 1'b1);
`endif

    // Address wrap modulo 2^32
    run_cmd(32'hFFFF_FFC0, 32'd128, 16'd1, 32'd0);
    chk("t4w_n", q_addr.size(), 2);
    chk_burst("t4w_b0", 0, 32'hFFFF_FFC0, 8'd15, 1'b0, 1'b0);
    chk_burst("t4w_b1", 1, 32'h0000_0000, 8'd15, 1'b1, 1'b1);

    // Rejected and empty commands: done the cycle after start is sampled, never valid
    run_cmd(32'h1002, 32'd256, 16'd1, 32'd0);
    chk("t5a_err", done_err, 1'b1);
    chk("t5a_done_at", done_at, 1);
    chk("t5a_no_valid", saw_valid, 1'b0);
    run_cmd(32'h1000, 32'd66, 16'd1, 32'd0);
    chk("t5b_err", done_err, 1'b1);
    chk("t5b_no_valid", saw_valid, 1'b0);
    run_cmd(32'h1000, 32'd256, 16'd0, 32'd0);
    chk("t5c_err", done_err, 1'b0);
    chk("t5c_done_at", done_at, 1);
    chk("t5c_no_valid", saw_valid, 1'b0);
    run_cmd(32'h1000, 32'd0, 16'd4, 32'd0);
    chk("t5d_err", done_err, 1'b0);
    chk("t5d_no_valid", saw_valid, 1'b0);

    // Asynchronous reset during S_EMIT
    @(negedge clk);
    base_addr = 32'h1000; row_bytes = 32'd256; num_rows = 16'd1; stride_bytes = 32'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("t6_valid", req_valid, 1'b0);
    chk("t6_addr", req_addr, 32'h0);
    chk("t6_flags", {req_len, req_row_last, req_last, busy, done, err}, 13'b0);
    @(negedge clk);
    chk("t6_no_done", done, 1'b0);
    rstn = 1'b1;
    run_cmd(32'h1000, 32'd256, 16'd1, 32'd0);
    chk_test1("t6r");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
